// File: rtl/switch_pulse_toggle.sv
// switch_pulse_toggle
// Turns a raw, bouncy, asynchronous button input into a debounced press:
// each accepted press produces a one-cycle o_ack strobe and flips o_level.
// A 2-flop synchronizer feeds a four-state debounce FSM that requires
// DEBOUNCE_CYCLES stable samples for both press and release.
// Optional feature: define SWITCH_PULSE_TOGGLE_LONG_EN to enable the
// long-press strobe o_long (otherwise o_long is tied low).
module switch_pulse_toggle #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned LONG_CYCLES     = 1000000,
    parameter int unsigned LCNT_W          = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pulse,
    input  logic i_clr,
    output logic o_level,
    output logic o_ack,
    output logic o_busy,
    output logic o_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time sanity checks on the parameter set.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (LONG_CYCLES < 1 || LCNT_W < 1) begin : g_bad_long
        $error("LONG_CYCLES and LCNT_W must be at least 1");
    end

    logic           s1_reg;
    logic           s2_reg;
    state_t         state_reg;
    state_t         state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic           accept;
    logic           level_reg;
    logic           ack_reg;
    logic           busy_reg;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= i_pulse;
            s2_reg <= s1_reg;
        end
    end

    // Debounce FSM state and stable-sample counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic; the terminal compare precedes the increment so the
    // counter never runs past DEBOUNCE_CYCLES-1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (s2_reg) begin
                    state_next = PRESS_DB;
                    cnt_next   = '0;
                end
            end
            PRESS_DB: begin
                if (!s2_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s2_reg) begin
                    state_next = RELEASE_DB;
                    cnt_next   = '0;
                end
            end
            RELEASE_DB: begin
                if (s2_reg) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Registered outputs: clear wins over a same-cycle toggle, ack still fires.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_reg <= 1'b0;
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            level_reg <= i_clr ? 1'b0 : (level_reg ^ accept);
            ack_reg   <= accept;
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign o_level = level_reg;
    assign o_ack   = ack_reg;
    assign o_busy  = busy_reg;

`ifdef SWITCH_PULSE_TOGGLE_LONG_EN
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

    logic [LCNT_W-1:0] lcnt_reg;
    logic              long_done_reg;
    logic              long_reg;
    logic              in_hold;

    assign in_hold = (state_reg == HELD) || (state_reg == RELEASE_DB);

    // Long-press timer: restarts on press acceptance, keeps running through
    // release bounce, fires once per press, and clears when IDLE is reached.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lcnt_reg      <= '0;
            long_done_reg <= 1'b0;
            long_reg      <= 1'b0;
        end else begin
            long_reg <= 1'b0;
            if (accept) begin
                lcnt_reg      <= '0;
                long_done_reg <= 1'b0;
            end else if (state_next == IDLE) begin
                lcnt_reg      <= '0;
                long_done_reg <= 1'b0;
            end else if (in_hold && !long_done_reg) begin
                if (lcnt_reg == LCNT_LAST) begin
                    long_reg      <= 1'b1;
                    long_done_reg <= 1'b1;
                end else begin
                    lcnt_reg <= lcnt_reg + LCNT_W'(1);
                end
            end
        end
    end

    assign o_long = long_reg;
`else
    assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_switch_pulse_toggle.sv
// Directed testbench for switch_pulse_toggle (DEBOUNCE_CYCLES=4, LONG_CYCLES=10),
// plus a second instance with DEBOUNCE_CYCLES=1 for the minimum-latency case.
// Edge numbers below count rising clock edges from the start of each stimulus.
module tb_switch_pulse_toggle;

    localparam int DB = 4;
`ifdef SWITCH_PULSE_TOGGLE_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pulse = 1'b0;
    logic clr = 1'b0;
    logic level, ack, busy, long_o;
    logic level1, ack1, busy1, long1;

    int n_tests = 0;
    int n_fail = 0;
    logic exp_level = 1'b0;

    switch_pulse_toggle #(
        .DEBOUNCE_CYCLES(DB), .CNT_W(4), .LONG_CYCLES(10), .LCNT_W(5)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse), .i_clr(clr),
        .o_level(level), .o_ack(ack), .o_busy(busy), .o_long(long_o)
    );

    switch_pulse_toggle #(
        .DEBOUNCE_CYCLES(1), .CNT_W(2)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pulse(pulse), .i_clr(clr),
        .o_level(level1), .o_ack(ack1), .o_busy(busy1), .o_long(long1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_v;
        rst_n = 1'b0; pulse = 1'b0; clr = 1'b0;
        tick(); tick();
        exp_v = 4'b0000;
        n_tests++;
        if ({ack, level, busy, long_o} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: {ack,level,busy,long}=%b expected %b", {ack, level, busy, long_o}, exp_v);
        end
        n_tests++;
        if ({ack1, level1, busy1, long1} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state_db1: {ack,level,busy,long}=%b expected %b", {ack1, level1, busy1, long1}, exp_v);
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if ({ack, level, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: {ack,level,busy}=%b expected 000", {ack, level, busy});
        end
        exp_level = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_v;
        logic [2:0] exp1;
        logic lvl0;
        lvl0 = exp_level;
        for (int e = 0; e < 20; e++) begin
            pulse = (e < 12);
            tick();
            exp_v = {e == 6, (e >= 6) ? ~lvl0 : lvl0, (e >= 2 && e <= 17), LONG_EN && (e == 16)};
            n_tests++;
            if ({ack, level, busy, long_o} !== exp_v) begin
                n_fail++;
                $display("FAIL clean_press e%0d: {ack,level,busy,long}=%b expected %b", e, {ack, level, busy, long_o}, exp_v);
            end
            exp1 = {e == 3, e >= 3, (e >= 2 && e <= 14)};
            n_tests++;
            if ({ack1, level1, busy1} !== exp1) begin
                n_fail++;
                $display("FAIL clean_press_db1 e%0d: {ack,level,busy}=%b expected %b", e, {ack1, level1, busy1}, exp1);
            end
        end
        exp_level = ~lvl0;
        $display("[TB] test_clean_press done, level=%b", level);
    endtask

    task automatic test_reset_mid_op();
        logic [2:0] exp_v;
        pulse = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        n_tests++;
        if ({level, busy} !== {exp_level, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset e3: {level,busy}=%b expected %b", {level, busy}, {exp_level, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ack, level, busy, long_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: {ack,level,busy,long}=%b expected 0000", {ack, level, busy, long_o});
        end
        tick();
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            exp_v = {e == 6, e >= 6, e >= 2};
            n_tests++;
            if ({ack, level, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_press e%0d: {ack,level,busy}=%b expected %b", e, {ack, level, busy}, exp_v);
            end
        end
        pulse = 1'b0;
        for (int e = 0; e < 8; e++) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: busy=%b expected 0", busy);
        end
        exp_level = 1'b1;
        $display("[TB] test_reset_mid_op done");
    endtask

    task automatic test_glitch();
        logic [3:0] exp_v;
        for (int e = 0; e < 10; e++) begin
            pulse = (e < 3);
            tick();
            exp_v = {1'b0, exp_level, (e >= 2 && e <= 4), 1'b0};
            n_tests++;
            if ({ack, level, busy, long_o} !== exp_v) begin
                n_fail++;
                $display("FAIL glitch e%0d: {ack,level,busy,long}=%b expected %b", e, {ack, level, busy, long_o}, exp_v);
            end
        end
        $display("[TB] test_glitch done");
    endtask

    task automatic test_bounce();
        logic [3:0] exp_v;
        logic lvl0;
        lvl0 = exp_level;
        // held through edge 11, then chatter 0,0,0,1,0,0,1,1 and stable low from edge 20
        for (int e = 0; e < 30; e++) begin
            pulse = (e < 12) || (e == 15) || (e == 18) || (e == 19);
            tick();
            exp_v = {e == 6, (e >= 6) ? ~lvl0 : lvl0, (e >= 2 && e <= 25), LONG_EN && (e == 16)};
            n_tests++;
            if ({ack, level, busy, long_o} !== exp_v) begin
                n_fail++;
                $display("FAIL bounce e%0d: {ack,level,busy,long}=%b expected %b", e, {ack, level, busy, long_o}, exp_v);
            end
        end
        exp_level = ~lvl0;
        $display("[TB] test_bounce done");
    endtask

    task automatic test_clear();
        logic [3:0] exp_v;
        logic lvl0, new_lvl;
        for (int p = 0; p < 4; p++) begin
            lvl0 = exp_level;
            new_lvl = (p == 2) ? 1'b0 : ~lvl0;
            for (int e = 0; e < 18; e++) begin
                pulse = (e < 10);
                clr = (p == 2) && (e == 6);
                tick();
                exp_v = {e == 6, (e >= 6) ? new_lvl : lvl0, (e >= 2 && e <= 15), 1'b0};
                n_tests++;
                if ({ack, level, busy, long_o} !== exp_v) begin
                    n_fail++;
                    $display("FAIL clear_press%0d e%0d: {ack,level,busy,long}=%b expected %b", p, e, {ack, level, busy, long_o}, exp_v);
                end
            end
            clr = 1'b0;
            exp_level = new_lvl;
            $display("[TB] clear press %0d: level=%b", p, level);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_tests++;
        if ({level, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_clear: {level,busy}=%b expected 00", {level, busy});
        end
        exp_level = 1'b0;
        $display("[TB] test_clear done");
    endtask

    task automatic test_long();
        logic [3:0] exp_v;
        logic lvl0;
        lvl0 = exp_level;
        for (int e = 0; e < 30; e++) begin
            pulse = (e < 20);
            tick();
            exp_v = {e == 6, (e >= 6) ? ~lvl0 : lvl0, (e >= 2 && e <= 25), LONG_EN && (e == 16)};
            n_tests++;
            if ({ack, level, busy, long_o} !== exp_v) begin
                n_fail++;
                $display("FAIL long_press e%0d: {ack,level,busy,long}=%b expected %b", e, {ack, level, busy, long_o}, exp_v);
            end
        end
        exp_level = ~lvl0;
        $display("[TB] test_long done (long feature %0d)", LONG_EN);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_reset_mid_op();
        test_glitch();
        test_bounce();
        test_clear();
        test_long();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_pulse_toggle.md
Name: switch_pulse_toggle

Overview:
- Receiving end of the switch/button pulse path: takes a raw, asynchronous, bouncy pulse input and turns each debounced press into a one-cycle acknowledge plus a toggled held level.
- Counterpart of the level-to-pulse generator: this block converts pulses back into a stable level.
- Sits between board pushbuttons and the clock-set/mode logic of the digital clock.

Parameters:
- DEBOUNCE_CYCLES, 50000, stable-input cycles required to accept a press or a release; must be >= 1.
- CNT_W, 16, debounce counter width; 2^CNT_W >= DEBOUNCE_CYCLES.
- LONG_CYCLES, 1000000, held cycles before o_long fires (used only with the optional feature).
- LCNT_W, 20, long-press counter width; 2^LCNT_W >= LONG_CYCLES.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pulse  in  1  raw button/pulse input, asynchronous to i_clk
- i_clr  in  1  synchronous clear of o_level
- o_level  out  1  toggled level; flips once per accepted press
- o_ack  out  1  one-cycle strobe on each accepted press
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_long  out  1  one-cycle long-press strobe (optional feature)

Behaviour:
- Reset: one clock, i_clk. Asynchronous active-low reset i_rst_n. While i_rst_n=0:
  - sync flops = 0, state = IDLE, counters = 0;
  - o_level = 0, o_ack = 0, o_busy = 0, o_long = 0.
  - Reset asserted mid-debounce or mid-hold aborts immediately. After release, a still-held input is treated as a new press.
- Synchronizer: i_pulse passes through a 2-flop synchronizer (s1 -> s2). The FSM uses only s2.
- States:
  - IDLE: s2=1 -> PRESS_DB, cnt=0. Otherwise stay.
  - PRESS_DB: s2=0 -> IDLE, cnt=0 (glitch rejected, no ack). s2=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, o_level toggles, o_ack=1 for that cycle. Otherwise cnt+1.
  - HELD: s2=0 -> RELEASE_DB, cnt=0. Otherwise stay.
  - RELEASE_DB: s2=1 -> HELD, cnt=0 (release bounce, no new ack). s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt+1.
- Latency: with i_pulse stable high from edge k, o_level toggles and o_ack is high on edge k+DEBOUNCE_CYCLES+2.
- o_ack: registered, high exactly one cycle per accepted press, never two cycles back to back.
- o_busy: registered, equal to (state != IDLE).
- i_clr: forces o_level=0 on the next edge.
  - Has priority over a same-cycle toggle: o_level=0, but o_ack still pulses.
  - Does not change state or counters.
- Counters: saturate-free. They never exceed DEBOUNCE_CYCLES-1 because the compare happens before the increment.
- DEBOUNCE_CYCLES=1: accepts after one stable s2 sample; latency = 3 edges.
- Input held indefinitely: exactly one toggle. No auto-repeat.

Optional Feature:
- Macro: SWITCH_PULSE_TOGGLE_LONG_EN.
- Defined:
  - A long counter clears on entry to HELD and increments each cycle in HELD.
  - It keeps counting through RELEASE_DB bounce that returns to HELD.
  - When it reaches LONG_CYCLES-1, o_long is high for one cycle, once per press.
  - The counter clears on the transition to IDLE.
  - o_level is unaffected.
- Not defined: o_long is tied to 0, and the long counter and LCNT_W logic are absent. Port list is unchanged.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10):
- Reset mid-operation: drive i_pulse=1 and deassert i_rst_n at edge 3 -> all outputs 0 immediately. After release with input still high, one new ack occurs 6 edges later.
- Clean press: i_pulse rises at edge 0 and stays high -> o_level 0->1 and o_ack=1 at edge 6 only; o_busy=1 from edge 2.
- Glitch: i_pulse high for 3 cycles, then low -> no ack, o_level stays 0, FSM back to IDLE, o_busy low by edge 7.
- Bounce: press accepted, then release with low-high-low chatter shorter than 4 cycles -> no second ack. IDLE is reached 4 stable-low cycles after the last chatter.
- Two presses with i_clr:
  - two full press/release cycles -> o_level goes 1, then 0;
  - i_clr asserted on a toggle cycle -> o_level=0, o_ack=1.
- Long press (macro defined): hold 20 cycles -> o_long pulses once, 10 cycles after HELD entry. Macro undefined -> o_long stays 0.
